// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin arbiter in front of one shared 16->32 immediate extender.
// The result is registered; out_valid/out_ready is a standard valid/ready handshake.
module imm_ext_arbiter #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IMM_W-1:0] req0_imm,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IMM_W-1:0] req1_imm,
  input  logic [1:0]       req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_src,
  output logic [1:0]       out_mode
);

  // Handshake: a requester transfers on the cycle reqN_valid & reqN_ready;
  // the consumer takes a result on the cycle out_valid & out_ready.

  if (OUT_W < IMM_W + 2) begin : g_bad_width
    $error("imm_ext_arbiter: OUT_W must be at least IMM_W+2");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_next;
  logic   rr, rr_next;
  logic   accept, gnt0, gnt1;
  logic [IMM_W-1:0] sel_imm;
  logic [1:0]       sel_mode;

  function automatic logic [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm,
                                              input logic [1:0] mode);
    logic [OUT_W-1:0] sx;
    sx = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (mode)
      2'b00:   extend = {{(OUT_W-IMM_W){1'b0}}, imm};
      2'b01:   extend = sx;
      2'b10:   extend = {imm, {(OUT_W-IMM_W){1'b0}}};
      default: extend = sx << 2;
    endcase
  endfunction

  // rr names the preferred requester when both are valid.
  always_comb begin
    accept     = (state == EMPTY) || out_ready;
    gnt0       = !rst && accept && req0_valid && (!req1_valid || !rr);
    gnt1       = !rst && accept && req1_valid && (!req0_valid || rr);
    rr_next    = rr;
    state_next = state;
    sel_imm    = gnt1 ? req1_imm : req0_imm;
    sel_mode   = gnt1 ? req1_mode : req0_mode;
    if (gnt0 || gnt1) begin
      rr_next    = gnt0;
      state_next = FULL;
    end else if (out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rr    <= 1'b0;
    end else begin
      state <= state_next;
      rr    <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= 1'b0;
      out_mode <= 2'b00;
    end else if (gnt0 || gnt1) begin
      out_data <= extend(sel_imm, sel_mode);
      out_src  <= gnt1;
      out_mode <= sel_mode;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign out_valid  = (state == FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: directed scenarios then random traffic, checked
// against a cycle-level reference model and a result scoreboard.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_imm = '0, req1_imm = '0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_src;
  logic [1:0]  out_mode;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_pref = 0;
  bit          m_full = 0;
  logic [31:0] m_data = '0;
  int          m_src  = 0;
  int          m_mode = 0;
  logic [31:0] exp_q[$];

  imm_ext_arbiter #(.IMM_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input int mode);
    int s;
    s = $signed(imm);
    case (mode)
      0:       return {16'h0000, imm};
      1:       return s;
      2:       return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  // One cycle: drive at negedge, compare settled outputs, advance model, wait for posedge.
  task automatic step(input bit r, input bit v0, input logic [15:0] i0, input logic [1:0] m0,
                      input bit v1, input logic [15:0] i1, input logic [1:0] m1, input bit ordy);
    bit can_take, w0, w1;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_imm = i0; req0_mode = m0;
    req1_valid = v1; req1_imm = i1; req1_mode = m1; out_ready = ordy;
    #1;
    can_take = !r && (!m_full || ordy);
    w0 = can_take && v0 && (!v1 || m_pref == 0);
    w1 = can_take && v1 && (!v0 || m_pref == 1);
    check("req0_ready", 32'(req0_ready), 32'(w0));
    check("req1_ready", 32'(req1_ready), 32'(w1));
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("out_data", out_data, m_data);
    check("out_src", 32'(out_src), 32'(m_src));
    check("out_mode", 32'(out_mode), 32'(m_mode));
    if (!r && out_valid && ordy) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("sb_result", out_data, exp_q.pop_front());
    end
    if (r) begin
      m_full = 0; m_data = '0; m_src = 0; m_mode = 0; m_pref = 0;
      exp_q.delete();
    end else if (w0 || w1) begin
      m_full = 1;
      m_src  = w1 ? 1 : 0;
      m_mode = w1 ? int'(m1) : int'(m0);
      m_data = w1 ? ref_ext(i1, m1) : ref_ext(i0, m0);
      m_pref = w1 ? 0 : 1;
      exp_q.push_back(m_data);
    end else if (ordy) begin
      m_full = 0;
    end
    @(posedge clk);
  endtask

  // Literal check of the registered result shortly after the edge.
  task automatic chk_out(input string tag, input logic [31:0] exp);
    #2;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, out_data, exp);
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, ordy);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // reset with both requesters pushing
    step(1, 1, 16'h1111, 2'b00, 1, 16'h2222, 2'b00, 1);
    step(1, 1, 16'h1111, 2'b00, 1, 16'h2222, 2'b00, 1);
    #2 check("post_reset_data", out_data, 32'h0);
    step(0, 1, 16'h1111, 2'b00, 1, 16'h2222, 2'b00, 1);
    #2 check("first_grant_src", 32'(out_src), 32'd0);
    idle(1);
    idle(1);

    // extension modes on req0
    step(0, 1, 16'h8000, 2'b01, 0, 16'h0, 2'b00, 1); chk_out("sext", 32'hFFFF8000);
    step(0, 1, 16'h8000, 2'b00, 0, 16'h0, 2'b00, 1); chk_out("zext", 32'h00008000);
    step(0, 1, 16'h1234, 2'b10, 0, 16'h0, 2'b00, 1); chk_out("upper", 32'h12340000);
    step(0, 1, 16'hFFFF, 2'b11, 0, 16'h0, 2'b00, 1); chk_out("branch", 32'hFFFFFFFC);
    idle(1);

    // contention: alternating grants, no gaps
    for (int i = 0; i < 8; i++)
      step(0, 1, 16'(i), 2'b00, 1, 16'(16'h100 + i), 2'b01, 1);
    idle(1);

    // backpressure with a req1 result held
    step(0, 0, 16'h0, 2'b00, 1, 16'h7FFF, 2'b01, 1); chk_out("bp_hold", 32'h00007FFF);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h0042, 2'b00, 0, 16'h0, 2'b00, 0);
      check("bp_stable", out_data, 32'h00007FFF);
    end
    step(0, 1, 16'h0042, 2'b00, 0, 16'h0, 2'b00, 1); chk_out("bp_release", 32'h00000042);
    idle(1);

    // reset while FULL and stalled
    step(0, 1, 16'h8000, 2'b01, 0, 16'h0, 2'b00, 1); chk_out("pre_rst", 32'hFFFF8000);
    idle(0);
    step(1, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 0);
    #2 check("rst_mid_valid", 32'(out_valid), 32'd0);
    idle(1);
    // rr back to 0 after reset
    step(0, 1, 16'h0001, 2'b00, 1, 16'h0002, 2'b00, 1);
    #2 check("rst_rr_src", 32'(out_src), 32'd0);

    // lone req0 wins while rr favours it anyway; then lone req0 after a req1 grant
    step(0, 0, 16'h0, 2'b00, 1, 16'h0003, 2'b00, 1);
    step(0, 1, 16'h0004, 2'b00, 0, 16'h0, 2'b00, 1);
    #2 check("lone_req0_src", 32'(out_src), 32'd0);
    step(0, 1, 16'h0005, 2'b00, 1, 16'h0006, 2'b00, 1);
    #2 check("rr_after_lone", 32'(out_src), 32'd1);
    idle(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           $urandom_range(0, 2) != 0, 16'($urandom), 2'($urandom),
           $urandom_range(0, 2) != 0, 16'($urandom), 2'($urandom),
           $urandom_range(0, 3) != 0);
    end
    idle(1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
